alu_req_arbiter: RTL and testbench

//  Shares one combinational ALU (addu/subu/AND/sll) between two requesters. Round-robin

---
 rtl/alu_req_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_arbiter
// Description : Shares one external combinational ALU (addu/subu/AND/sll)
//               between two requesters. Round-robin grant, registered ALU
//               operands held for a settle window before result capture, and
//               valid/ready handshakes on the request and response sides.
//               Illegal Funct codes are answered with an error response and
//               never presented to the ALU.
// Ports       : clk, rst            clock, synchronous active-high reset
//               req_valid/req_ready per-requester request handshake
//               req_src1/src2/shamt/funct  packed {r1,r0} operands
//               rsp_valid/rsp_ready per-requester response handshake
//               rsp_result/rsp_err  response payload for the current owner
//               alu_src1/src2/shamt/funct  registered operands to the ALU
//               alu_result          combinational result from the ALU
//               busy                high whenever the FSM is not idle
// Revision    : 1.0  initial release
// ============================================================================
module alu_req_arbiter #(
    parameter int DATA_W     = 32,
    parameter int SETTLE_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_src1,
    input  logic [2*DATA_W-1:0] req_src2,
    input  logic [9:0]          req_shamt,
    input  logic [11:0]         req_funct,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   alu_src1,
    output logic [DATA_W-1:0]   alu_src2,
    output logic [4:0]          alu_shamt,
    output logic [5:0]          alu_funct,
    input  logic [DATA_W-1:0]   alu_result,
    output logic                busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [5:0] C_F_ADDU = 6'b001001;
    localparam logic [5:0] C_F_SUBU = 6'b001010;
    localparam logic [5:0] C_F_AND  = 6'b010001;
    localparam logic [5:0] C_F_SLL  = 6'b100001;

    localparam int              CNT_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner;
    logic              r_last;      // requester served most recently
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_alu_src1;
    logic [DATA_W-1:0] r_alu_src2;
    logic [4:0]        r_alu_shamt;
    logic [5:0]        r_alu_funct;

    logic [1:0]        w_grant;
    logic              w_gidx;
    logic [5:0]        w_sel_funct;
    logic              w_sel_legal;
    logic              w_accept;
    logic              w_rsp_take;

    // Grant: single requester wins outright; on contention the one not
    // served last wins. Reset sets r_last=1 so requester 0 is preferred.
    always_comb begin
        w_grant = 2'b00;
        case (req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    assign w_gidx      = w_grant[1];
    assign w_sel_funct = w_gidx ? req_funct[11:6] : req_funct[5:0];

    always_comb begin
        w_sel_legal = 1'b0;
        case (w_sel_funct)
            C_F_ADDU, C_F_SUBU, C_F_AND, C_F_SLL: w_sel_legal = 1'b1;
            default:                              w_sel_legal = 1'b0;
        endcase
    end

    assign w_accept   = (r_state == S_IDLE) && (w_grant != 2'b00);
    assign w_rsp_take = (r_state == S_RESP) && rsp_ready[r_owner];

    assign req_ready  = (r_state == S_IDLE) ? w_grant : 2'b00;
    assign rsp_valid  = (r_state == S_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result = r_rsp_result;
    assign rsp_err    = r_rsp_err;
    assign alu_src1   = r_alu_src1;
    assign alu_src2   = r_alu_src2;
    assign alu_shamt  = r_alu_shamt;
    assign alu_funct  = r_alu_funct;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_owner      <= 1'b0;
            r_last       <= 1'b1;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            r_alu_src1   <= '0;
            r_alu_src2   <= '0;
            r_alu_shamt  <= '0;
            r_alu_funct  <= C_F_ADDU;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_gidx;
                        if (w_sel_legal) begin
                            r_alu_src1  <= w_gidx ? req_src1[2*DATA_W-1:DATA_W] : req_src1[DATA_W-1:0];
                            r_alu_src2  <= w_gidx ? req_src2[2*DATA_W-1:DATA_W] : req_src2[DATA_W-1:0];
                            r_alu_shamt <= w_gidx ? req_shamt[9:5] : req_shamt[4:0];
                            r_alu_funct <= w_sel_funct;
                            r_cnt       <= C_CNT_LOAD;
                            r_state     <= S_EXEC;
                        end else begin
                            // Illegal op bypasses the ALU; alu_* keep their old values.
                            r_rsp_result <= '0;
                            r_rsp_err    <= 1'b1;
                            r_state      <= S_RESP;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_rsp_result <= alu_result;
                        r_rsp_err    <= 1'b0;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_rsp_take) begin
                        r_last  <= r_owner;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_req_arbiter
// Description : Directed self-checking bench for alu_req_arbiter with a
//               behavioural ALU stub and an expected-response queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_req_arbiter;

    localparam int         DATA_W     = 32;
    localparam int         SETTLE_CYC = 1;
    localparam logic [5:0] F_ADDU     = 6'b001001;
    localparam logic [5:0] F_SUBU     = 6'b001010;
    localparam logic [5:0] F_AND      = 6'b010001;
    localparam logic [5:0] F_SLL      = 6'b100001;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [1:0]          req_valid = 2'b00;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_src1 = '0;
    logic [2*DATA_W-1:0] req_src2 = '0;
    logic [9:0]          req_shamt = '0;
    logic [11:0]         req_funct = '0;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready = 2'b00;
    logic [DATA_W-1:0]   rsp_result;
    logic                rsp_err;
    logic [DATA_W-1:0]   alu_src1;
    logic [DATA_W-1:0]   alu_src2;
    logic [4:0]          alu_shamt;
    logic [5:0]          alu_funct;
    logic [DATA_W-1:0]   alu_result;
    logic                busy;

    always #5 clk = ~clk;

    alu_req_arbiter #(.DATA_W(DATA_W), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2),
        .req_shamt(req_shamt), .req_funct(req_funct),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_shamt(alu_shamt), .alu_funct(alu_funct),
        .alu_result(alu_result), .busy(busy)
    );

    // Behavioural ALU; unknown codes give a marker value that must never show.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        if (alu_funct == F_ADDU)      alu_result = alu_src1 + alu_src2;
        else if (alu_funct == F_SUBU) alu_result = alu_src1 - alu_src2;
        else if (alu_funct == F_AND)  alu_result = alu_src1 & alu_src2;
        else if (alu_funct == F_SLL)  alu_result = alu_src2 << alu_shamt;
    end

    typedef struct packed {
        logic        owner;
        logic        err;
        logic [31:0] res;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] op_src1[2];
    logic [31:0] op_src2[2];
    logic [4:0]  op_shamt[2];
    logic [5:0]  op_funct[2];

    function automatic logic [32:0] model(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        case (f)
            F_ADDU:  return {1'b0, a + b};
            F_SUBU:  return {1'b0, a - b};
            F_AND:   return {1'b0, a & b};
            F_SLL:   return {1'b0, b << sh};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int who, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
        op_funct[who] = f; op_src1[who] = a; op_src2[who] = b; op_shamt[who] = sh;
        req_funct[who*6 +: 6]   = f;
        req_src1[who*32 +: 32]  = a;
        req_src2[who*32 +: 32]  = b;
        req_shamt[who*5 +: 5]   = sh;
    endtask

    // Call at a negedge with requests driven. Returns after the accepting edge.
    task automatic grab(input bit drop, output int g);
        bit          got = 1'b0;
        logic [32:0] m;
        exp_t        e;
        g = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if ((req_ready & req_valid) != 2'b00) begin
                got = 1'b1;
                g   = req_ready[1] ? 1 : 0;
            end else begin
                @(negedge clk);
            end
        end
        check("grant_seen", {63'd0, got}, 64'd1);
        if (got) begin
            m = model(op_funct[g], op_src1[g], op_src2[g], op_shamt[g]);
            e.owner = g[0]; e.err = m[32]; e.res = m[31:0];
            sb.push_back(e);
            @(posedge clk); #1;
            if (drop) req_valid[g] = 1'b0;
        end
    endtask

    // Waits for the response, checks latency/payload, optionally stalls with
    // rsp_ready on the non-owner bit for 'hold' cycles, then acknowledges.
    task automatic collect(input int hold);
        int   k    = 0;
        bit   seen = 1'b0;
        int   lat;
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_nonempty", 64'd0, 64'd1);
            return;
        end
        e   = sb.pop_front();
        lat = e.err ? 1 : SETTLE_CYC + 1;
        while (k < 20 && !seen) begin
            @(negedge clk); #1;
            k++;
            if (rsp_valid != 2'b00) seen = 1'b1;
            else check("req_ready_busy", {62'd0, req_ready}, 64'd0);
        end
        check("rsp_latency", k, lat);
        check("rsp_valid", {62'd0, rsp_valid}, e.owner ? 64'd2 : 64'd1);
        check("rsp_result", {32'd0, rsp_result}, {32'd0, e.res});
        check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
        for (int h = 0; h < hold; h++) begin
            rsp_ready = e.owner ? 2'b01 : 2'b10;
            @(negedge clk); #1;
            check("hold_valid", {62'd0, rsp_valid}, e.owner ? 64'd2 : 64'd1);
            check("hold_result", {32'd0, rsp_result}, {32'd0, e.res});
            check("hold_req_ready", {62'd0, req_ready}, 64'd0);
        end
        rsp_ready = e.owner ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        check("rsp_cleared", {62'd0, rsp_valid}, 64'd0);
        check("idle_after_rsp", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int g;

        // 1. Reset
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_alu_funct", {58'd0, alu_funct}, {58'd0, F_ADDU});
        check("rst_alu_src1", {32'd0, alu_src1}, 64'd0);
        check("rst_req_ready", {62'd0, req_ready}, 64'd0);
        check("rst_rsp_result", {32'd0, rsp_result}, 64'd0);
        rst = 1'b0;

        // 2. r0 addu wraps to 1
        @(negedge clk);
        set_op(0, F_ADDU, 32'hFFFF_FFFF, 32'h2, 5'd0);
        req_valid = 2'b01;
        grab(1'b1, g);
        check("t2_grant", g, 0);
        check("t2_alu_src1", {32'd0, alu_src1}, 64'hFFFF_FFFF);
        check("t2_busy", {63'd0, busy}, 64'd1);
        collect(0);

        // 4. r1 illegal funct: immediate error response, ALU operands untouched
        @(negedge clk);
        set_op(1, 6'b000000, 32'h1234, 32'h5678, 5'd3);
        req_valid = 2'b10;
        grab(1'b1, g);
        check("t4_grant", g, 1);
        collect(0);
        check("t4_alu_src1", {32'd0, alu_src1}, 64'hFFFF_FFFF);
        check("t4_alu_src2", {32'd0, alu_src2}, 64'h2);
        check("t4_alu_funct", {58'd0, alu_funct}, {58'd0, F_ADDU});

        // 3. Both requesters continuously valid: grants alternate 0,1,0,1
        @(negedge clk);
        set_op(0, F_SUBU, 32'd5, 32'd7, 5'd9);
        set_op(1, F_SLL, 32'd0, 32'd1, 5'd31);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            grab(1'b0, g);
            check("t3_rr_grant", g, i % 2);
            collect(0);
            @(negedge clk);
        end

        // 5. Response stall with both requests pending and non-owner rsp_ready
        grab(1'b0, g);
        check("t5_grant", g, 0);
        collect(5);
        @(negedge clk);
        req_valid = 2'b00;

        // 6. Reset during EXEC discards the op
        set_op(0, F_AND, 32'hAAAA_5555, 32'h1234_5678, 5'd2);
        req_valid = 2'b01;
        grab(1'b1, g);
        check("t6_exec_busy", {63'd0, busy}, 64'd1);
        void'(sb.pop_back());
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_rst_busy", {63'd0, busy}, 64'd0);
        check("t6_rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        check("t6_rst_alu_funct", {58'd0, alu_funct}, {58'd0, F_ADDU});
        check("t6_rst_alu_src1", {32'd0, alu_src1}, 64'd0);
        @(negedge clk); #1;
        check("t6_no_rsp", {62'd0, rsp_valid}, 64'd0);
        set_op(0, F_AND, 32'hF0F0, 32'hFF00, 5'd0);
        req_valid = 2'b01;
        grab(1'b1, g);
        check("t6_grant", g, 0);
        collect(0);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
